// File: rtl/io_controller_if.sv
// CPU handshake and RAM port bundle for io_controller.
// The bidirectional CPU_Bus stays a plain inout port on the controller.
interface io_controller_if #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64
);
  logic                     INT;
  logic                     Load_Process;
  logic                     Bus_Valid;
  logic                     Bus_Ready;
  logic                     Send_Valid;
  logic                     Busy;
  logic                     Done_Loading;
  logic                     Done_Sending;
  logic                     Overrun;
  logic                     IO_Memory_WR_Enable;
  logic [DATA_WIDTH-1:0]    RAM_Data_WR;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_WR;
  logic [DATA_WIDTH-1:0]    RAM_Data_RD_A;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A;

  modport slave (
    input  INT, Load_Process, Bus_Valid, Bus_Ready, RAM_Data_RD_A,
    output Send_Valid, Busy, Done_Loading, Done_Sending, Overrun,
           IO_Memory_WR_Enable, RAM_Data_WR, RAM_Address_WR, RAM_Address_RD_A
  );

  modport master (
    output INT, Load_Process, Bus_Valid, Bus_Ready, RAM_Data_RD_A,
    input  Send_Valid, Busy, Done_Loading, Done_Sending, Overrun,
           IO_Memory_WR_Enable, RAM_Data_WR, RAM_Address_WR, RAM_Address_RD_A
  );
endinterface

// File: rtl/io_controller.sv
// CPU <-> RAM transfer controller: loads word-assembled beats into RAM, sends result words back.
//   state      | meaning
//   IDLE       | waiting for INT; Load_Process picks the command
//   LOAD_HDR   | waiting for the word-count header beat
//   LOAD_DATA  | accepting beats, writing each completed word
//   LOAD_FLUSH | last word write presented, Done_Loading follows
//   SEND_READ  | RAM read address presented
//   SEND_WAIT  | RAM read latency cycle, data latched at its end
//   SEND_DRIVE | driving send-register slices on CPU_Bus
module io_controller #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int BUS_WIDTH     = 32,
  parameter int LOAD_BASE     = 0,
  parameter int RESULT_BASE   = 0,
  parameter int RESULT_COUNT  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  io_controller_if.slave       io,
  inout  wire [BUS_WIDTH-1:0]  CPU_Bus
);
  localparam int BEATS  = DATA_WIDTH / BUS_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (RESULT_COUNT > 1) ? $clog2(RESULT_COUNT) : 1;
  localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDRESS_WIDTH:0] ONE_WORD  = (ADDRESS_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    IDLE, LOAD_HDR, LOAD_DATA, LOAD_FLUSH, SEND_READ, SEND_WAIT, SEND_DRIVE
  } state_t;

  state_t                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [ADDRESS_WIDTH:0]   words_q, words_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    asm_q, asm_d;
  logic                     wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic [DATA_WIDTH-1:0]    send_q, send_d;
  logic                     done_load_q, done_load_d;
  logic                     done_send_q, done_send_d;
  logic                     overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    words_d     = words_q;
    addr_d      = addr_q;
    asm_d       = asm_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    wr_addr_d   = wr_addr_q;
    index_d     = index_q;
    send_d      = send_q;
    done_load_d = 1'b0;
    done_send_d = 1'b0;
    overrun_d   = io.INT && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        beat_d  = '0;
        index_d = '0;
        if (io.INT) state_d = io.Load_Process ? LOAD_HDR : SEND_READ;
      end
      LOAD_HDR: begin
        if (io.Bus_Valid) begin
          words_d = CPU_Bus[ADDRESS_WIDTH:0];
          if (CPU_Bus[ADDRESS_WIDTH:0] == '0) begin
            done_load_d = 1'b1;
            state_d     = IDLE;
          end else begin
            beat_d  = '0;
            addr_d  = ADDRESS_WIDTH'(LOAD_BASE);
            state_d = LOAD_DATA;
          end
        end
      end
      LOAD_DATA: begin
        if (io.Bus_Valid) begin
          asm_d[beat_q*BUS_WIDTH +: BUS_WIDTH] = CPU_Bus;
          if (beat_q == LAST_BEAT) begin
            // Completed word goes out as a registered write next cycle.
            beat_d    = '0;
            wr_en_d   = 1'b1;
            wr_data_d = asm_d;
            wr_addr_d = addr_q;
            addr_d    = addr_q + 1'b1;
            if (words_q == ONE_WORD) state_d = LOAD_FLUSH;
            else                     words_d = words_q - 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      LOAD_FLUSH: begin
        done_load_d = 1'b1;
        state_d     = IDLE;
      end
      SEND_READ: state_d = SEND_WAIT;
      SEND_WAIT: begin
        send_d  = io.RAM_Data_RD_A;
        beat_d  = '0;
        state_d = SEND_DRIVE;
      end
      SEND_DRIVE: begin
        if (io.Bus_Ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if ((32'(index_q) + 32'd1) < 32'(RESULT_COUNT)) begin
              index_d = index_q + 1'b1;
              state_d = SEND_READ;
            end else begin
              index_d     = '0;
              done_send_d = 1'b1;
              state_d     = IDLE;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      words_q     <= '0;
      addr_q      <= '0;
      asm_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      index_q     <= '0;
      send_q      <= '0;
      done_load_q <= 1'b0;
      done_send_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      words_q     <= words_d;
      addr_q      <= addr_d;
      asm_q       <= asm_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
      index_q     <= index_d;
      send_q      <= send_d;
      done_load_q <= done_load_d;
      done_send_q <= done_send_d;
      overrun_q   <= overrun_d;
    end
  end

  // A write already registered is dropped if reset arrives in its cycle.
  assign io.IO_Memory_WR_Enable = wr_en_q & RST;
  assign io.RAM_Data_WR         = wr_data_q;
  assign io.RAM_Address_WR      = wr_addr_q;
  assign io.RAM_Address_RD_A    = (state_q == SEND_READ)
                                  ? ADDRESS_WIDTH'(RESULT_BASE) + ADDRESS_WIDTH'(index_q)
                                  : '0;
  assign io.Send_Valid          = (state_q == SEND_DRIVE);
  assign io.Busy                = (state_q != IDLE);
  assign io.Done_Loading        = done_load_q;
  assign io.Done_Sending        = done_send_q;
  assign io.Overrun             = overrun_q;
  assign CPU_Bus = (state_q == SEND_DRIVE) ? send_q[beat_q*BUS_WIDTH +: BUS_WIDTH] : 'z;
endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: loads, sends, stalls, overrun, reset abort, empty header.
module tb_io_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_en = 1'b0;
  logic [31:0] bus_drv = '0;
  wire  [31:0] cpu_bus;
  int          checks = 0;
  int          failures = 0;

  io_controller_if #(.ADDRESS_WIDTH(13), .DATA_WIDTH(64)) bus_if ();

  assign cpu_bus = bus_en ? bus_drv : 'z;

  io_controller #(.RESULT_COUNT(2)) dut (
    .CLK(clk), .RST(rst_n), .io(bus_if), .CPU_Bus(cpu_bus)
  );

  always #5 clk = ~clk;

  logic [63:0] ram [0:8191];
  always @(posedge clk) begin
    if (bus_if.IO_Memory_WR_Enable) ram[bus_if.RAM_Address_WR] <= bus_if.RAM_Data_WR;
    bus_if.RAM_Data_RD_A <= ram[bus_if.RAM_Address_RD_A];
  end

  // Event log sampled on the falling edge
  int          cyc = 0;
  int          wr_n = 0, dl_n = 0, ds_n = 0, ov_n = 0;
  int          dl_c = 0;
  logic [12:0] wr_a [0:63];
  logic [63:0] wr_d [0:63];
  int          wr_c [0:63];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus_if.IO_Memory_WR_Enable) begin
      if (wr_n < 64) begin
        wr_a[wr_n] <= bus_if.RAM_Address_WR;
        wr_d[wr_n] <= bus_if.RAM_Data_WR;
        wr_c[wr_n] <= cyc;
      end
      wr_n <= wr_n + 1;
    end
    if (bus_if.Done_Loading) begin dl_n <= dl_n + 1; dl_c <= cyc; end
    if (bus_if.Done_Sending) ds_n <= ds_n + 1;
    if (bus_if.Overrun) ov_n <= ov_n + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cmd(input logic is_load);
    bus_if.INT = 1'b1; bus_if.Load_Process = is_load;
    tick();
    bus_if.INT = 1'b0; bus_if.Load_Process = 1'b0;
  endtask

  task automatic load_stream(input int n, input logic [31:0] beats [0:7], input int int_at);
    bus_en = 1'b1; bus_if.Bus_Valid = 1'b1; bus_drv = 32'(n);
    tick();
    for (int i = 0; i < 2*n; i++) begin
      bus_drv = beats[i];
      bus_if.INT = (i == int_at);
      tick();
    end
    bus_if.INT = 1'b0; bus_if.Bus_Valid = 1'b0; bus_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus_if.INT = 1'b1; bus_if.Load_Process = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({bus_if.Busy, bus_if.IO_Memory_WR_Enable, bus_if.Send_Valid, bus_if.Done_Loading,
         bus_if.Done_Sending, bus_if.Overrun} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b%b%b%b%b exp=000000", bus_if.Busy, bus_if.IO_Memory_WR_Enable,
               bus_if.Send_Valid, bus_if.Done_Loading, bus_if.Done_Sending, bus_if.Overrun);
    end
    checks++;
    if ({bus_if.RAM_Address_WR, bus_if.RAM_Data_WR, bus_if.RAM_Address_RD_A} !== '0) begin
      failures++;
      $display("FAIL reset_ram_ports got wa=%h wd=%h ra=%h exp=0", bus_if.RAM_Address_WR,
               bus_if.RAM_Data_WR, bus_if.RAM_Address_RD_A);
    end
    bus_if.INT = 1'b0; bus_if.Load_Process = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ignore_idle();
    int w0;
    w0 = wr_n;
    bus_if.Bus_Valid = 1'b1; bus_if.Bus_Ready = 1'b1; bus_en = 1'b1; bus_drv = 32'h5;
    tick(); tick(); tick();
    bus_if.Bus_Valid = 1'b0; bus_if.Bus_Ready = 1'b0; bus_en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.Busy !== 1'b0 || bus_if.Send_Valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore busy=%b send_valid=%b exp=0/0", bus_if.Busy, bus_if.Send_Valid);
    end
    tick();
    checks++;
    if (wr_n - w0 != 0) begin
      failures++;
      $display("FAIL idle_ignore_writes got=%0d exp=0", wr_n - w0);
    end
  endtask

  task automatic test_load();
    logic [31:0] b [0:7];
    int w0, d0;
    b = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 0, 0};
    w0 = wr_n; d0 = dl_n;
    cmd(1'b1);
    @(negedge clk);
    checks++;
    if (bus_if.Busy !== 1'b1) begin
      failures++; $display("FAIL load_busy got=%b exp=1", bus_if.Busy);
    end
    tick();
    load_stream(2, b, -1);
    repeat (4) tick();
    checks++;
    if (wr_n - w0 != 2) begin
      failures++; $display("FAIL load_write_count got=%0d exp=2", wr_n - w0);
    end else begin
      checks++;
      if (wr_a[w0] !== 13'd0 || wr_d[w0] !== 64'h2222222211111111) begin
        failures++; $display("FAIL load_word0 got=%h@%0d exp=2222222211111111@0", wr_d[w0], wr_a[w0]);
      end
      checks++;
      if (wr_a[w0+1] !== 13'd1 || wr_d[w0+1] !== 64'h4444444433333333) begin
        failures++; $display("FAIL load_word1 got=%h@%0d exp=4444444433333333@1", wr_d[w0+1], wr_a[w0+1]);
      end
      checks++;
      if (wr_c[w0+1] - wr_c[w0] != 2) begin
        failures++; $display("FAIL load_write_spacing got=%0d exp=2", wr_c[w0+1] - wr_c[w0]);
      end
      checks++;
      if (dl_c != wr_c[w0+1] + 1) begin
        failures++; $display("FAIL load_done_timing got=%0d exp=%0d", dl_c, wr_c[w0+1] + 1);
      end
    end
    checks++;
    if (dl_n - d0 != 1 || bus_if.Busy !== 1'b0) begin
      failures++; $display("FAIL load_done_count got=%0d busy=%b exp=1 busy=0", dl_n - d0, bus_if.Busy);
    end
  endtask

  task automatic test_send();
    logic [31:0] got [0:7];
    int nb, k_last, k_done, w0, d0;
    nb = 0; k_last = -1; k_done = -1; w0 = wr_n; d0 = ds_n;
    ram[0] = 64'hAABBCCDD00112233;
    ram[1] = 64'h5566778899AA0011;
    bus_if.Bus_Ready = 1'b1;
    cmd(1'b0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus_if.Send_Valid && nb < 8) begin got[nb] = cpu_bus; nb++; k_last = k; end
      if (bus_if.Done_Sending) k_done = k;
    end
    bus_if.Bus_Ready = 1'b0;
    checks++;
    if (nb != 4) begin
      failures++; $display("FAIL send_beat_count got=%0d exp=4", nb);
    end else begin
      checks++;
      if (got[0] !== 32'h00112233 || got[1] !== 32'hAABBCCDD) begin
        failures++; $display("FAIL send_word0 got=%h %h exp=00112233 aabbccdd", got[0], got[1]);
      end
      checks++;
      if (got[2] !== 32'h99AA0011 || got[3] !== 32'h55667788) begin
        failures++; $display("FAIL send_word1 got=%h %h exp=99aa0011 55667788", got[2], got[3]);
      end
    end
    checks++;
    if (k_done != k_last + 1 || ds_n - d0 != 1) begin
      failures++; $display("FAIL send_done got_at=%0d pulses=%0d exp_at=%0d pulses=1", k_done, ds_n - d0, k_last + 1);
    end
    checks++;
    if (wr_n - w0 != 0) begin
      failures++; $display("FAIL send_no_write got=%0d exp=0", wr_n - w0);
    end
  endtask

  task automatic test_ready_stall();
    logic [31:0] first;
    int seen, stable, d0;
    seen = 0; stable = 1; d0 = ds_n;
    ram[0] = 64'hCAFEF00D12345678;
    ram[1] = 64'h0000000100000002;
    bus_if.Bus_Ready = 1'b0;
    cmd(1'b0);
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (bus_if.Send_Valid) seen = 1;
    end
    first = cpu_bus;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cpu_bus !== first || bus_if.Send_Valid !== 1'b1) stable = 0;
    end
    checks++;
    if (seen != 1 || first !== 32'h12345678 || stable != 1) begin
      failures++; $display("FAIL stall_hold got=%h seen=%0d stable=%0d exp=12345678 1 1", first, seen, stable);
    end
    bus_if.Bus_Ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_bus !== 32'hCAFEF00D || bus_if.Send_Valid !== 1'b1) begin
      failures++; $display("FAIL stall_advance got=%h sv=%b exp=cafef00d sv=1", cpu_bus, bus_if.Send_Valid);
    end
    repeat (10) @(negedge clk);
    bus_if.Bus_Ready = 1'b0;
    checks++;
    if (ds_n - d0 != 1 || bus_if.Busy !== 1'b0) begin
      failures++; $display("FAIL stall_done pulses=%0d busy=%b exp=1 0", ds_n - d0, bus_if.Busy);
    end
    tick();
  endtask

  task automatic test_overrun();
    logic [31:0] b [0:7];
    int w0, d0, o0;
    b = '{32'hDEADBEEF, 32'h0BADF00D, 0, 0, 0, 0, 0, 0};
    w0 = wr_n; d0 = dl_n; o0 = ov_n;
    cmd(1'b1);
    load_stream(1, b, 0);
    repeat (4) tick();
    checks++;
    if (ov_n - o0 != 1) begin
      failures++; $display("FAIL overrun_pulses got=%0d exp=1", ov_n - o0);
    end
    checks++;
    if (wr_n - w0 != 1 || wr_d[w0] !== 64'h0BADF00DDEADBEEF || wr_a[w0] !== 13'd0) begin
      failures++; $display("FAIL overrun_load got=%0d writes %h@%0d exp=1 0badf00ddeadbeef@0", wr_n - w0, wr_d[w0], wr_a[w0]);
    end
    checks++;
    if (dl_n - d0 != 1) begin
      failures++; $display("FAIL overrun_done got=%0d exp=1", dl_n - d0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] b [0:7];
    int w0, d0;
    b = '{32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0, 0, 0};
    w0 = wr_n; d0 = dl_n;
    cmd(1'b1);
    load_stream(1, b, -1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (wr_n - w0 != 0 || dl_n - d0 != 0 || bus_if.Busy !== 1'b0) begin
      failures++; $display("FAIL reset_abort writes=%0d done=%0d busy=%b exp=0 0 0", wr_n - w0, dl_n - d0, bus_if.Busy);
    end
  endtask

  task automatic test_zero_hdr();
    int w0;
    w0 = wr_n;
    cmd(1'b1);
    bus_en = 1'b1; bus_drv = 32'h0; bus_if.Bus_Valid = 1'b1;
    tick();
    bus_en = 1'b0; bus_if.Bus_Valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.Done_Loading !== 1'b1) begin
      failures++; $display("FAIL zero_hdr_done got=%b exp=1", bus_if.Done_Loading);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus_if.Done_Loading !== 1'b0 || bus_if.Busy !== 1'b0 || wr_n - w0 != 0) begin
      failures++; $display("FAIL zero_hdr_after done=%b busy=%b writes=%0d exp=0 0 0", bus_if.Done_Loading, bus_if.Busy, wr_n - w0);
    end
  endtask

  initial begin
    bus_if.INT = 1'b0; bus_if.Load_Process = 1'b0;
    bus_if.Bus_Valid = 1'b0; bus_if.Bus_Ready = 1'b0;
    for (int i = 0; i < 8192; i++) ram[i] = '0;
    test_reset();
    test_ignore_idle();
    test_load();
    test_send();
    test_ready_stall();
    test_overrun();
    test_reset_mid();
    test_zero_hdr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/io_controller.md
IO_CONTROLLER -- requirements
Module: io_controller

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 13, the RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, the RAM word width.
REQ-003 SHALL have parameter BUS_WIDTH, default 32, the CPU bus width; DATA_WIDTH SHALL be an integer multiple of BUS_WIDTH; BEATS = DATA_WIDTH/BUS_WIDTH.
REQ-004 SHALL have parameters LOAD_BASE (default 0), RESULT_BASE (default 0) and RESULT_COUNT (default 1), giving the start addresses and the number of result words to send.
REQ-005 SHALL have one clock and a synchronous, active-low reset, with the ports named CLK and RST as elsewhere in the codebase:
  CLK  in  1  rising-edge clock
  RST  in  1  synchronous reset, active low
  INT  in  1  CPU command strobe, sampled when idle
  Load_Process  in  1  command type: 1 = load, 0 = send
  CPU_Bus  inout  BUS_WIDTH  bidirectional CPU data
  Bus_Valid  in  1  CPU word on CPU_Bus is valid (load)
  Bus_Ready  in  1  CPU accepts the driven word (send)
  Send_Valid  out  1  block drives a valid word on CPU_Bus
  Busy  out  1  state is not IDLE
  Done_Loading  out  1  one-cycle pulse at the end of a load
  Done_Sending  out  1  one-cycle pulse at the end of a send
  Overrun  out  1  one-cycle pulse when INT is asserted while Busy
  IO_Memory_WR_Enable  out  1  RAM write strobe
  RAM_Data_WR  out  DATA_WIDTH  RAM write data
  RAM_Address_WR  out  ADDRESS_WIDTH  RAM write address
  RAM_Data_RD_A  in  DATA_WIDTH  RAM read data, registered one cycle after the address
  RAM_Address_RD_A  out  ADDRESS_WIDTH  RAM read address

Function
REQ-006 SHALL implement an FSM with states IDLE, LOAD_HDR, LOAD_DATA, LOAD_FLUSH, SEND_READ, SEND_WAIT, SEND_DRIVE.
REQ-007 IDLE: INT=1 with Load_Process=1 SHALL go to LOAD_HDR; INT=1 with Load_Process=0 SHALL go to SEND_READ; the command type SHALL be latched, not held combinationally.
REQ-008 LOAD_HDR: on Bus_Valid, SHALL capture CPU_Bus[ADDRESS_WIDTH:0] as word count N; N=0 SHALL give Done_Loading the next cycle and return to IDLE; otherwise go to LOAD_DATA with beat=0 and address=LOAD_BASE.
REQ-009 LOAD_DATA: each Bus_Valid SHALL store CPU_Bus into slice [beat*BUS_WIDTH +: BUS_WIDTH] of the assembly register (first beat = least significant) and increment beat.
REQ-010 On acceptance of beat BEATS-1, the next cycle SHALL present IO_Memory_WR_Enable=1 for exactly one cycle with the assembled word and the current address; then address +1 (modulo 2^ADDRESS_WIDTH) and beat=0.
REQ-011 LOAD_DATA SHALL keep accepting beats in the cycle the write is presented (no back-pressure, one beat per cycle sustained).
REQ-012 After accepting the final beat of word N, SHALL enter LOAD_FLUSH; the write of word N occurs there; Done_Loading SHALL pulse the cycle after that write; then IDLE.
REQ-013 SEND_READ SHALL drive RAM_Address_RD_A = RESULT_BASE + index, then SEND_WAIT for one cycle, then latch RAM_Data_RD_A into the send register and enter SEND_DRIVE.
REQ-014 SEND_DRIVE SHALL drive CPU_Bus with slice beat of the send register and Send_Valid=1; on Bus_Ready, beat SHALL advance; after beat BEATS-1 is accepted: index+1 < RESULT_COUNT goes to SEND_READ, otherwise Done_Sending pulses the next cycle and the FSM returns to IDLE.
REQ-015 CPU_Bus SHALL be high-impedance in every state except SEND_DRIVE.
REQ-016 INT while Busy SHALL be ignored for state and SHALL pulse Overrun for one cycle.
REQ-017 Bus_Valid outside LOAD_HDR/LOAD_DATA and Bus_Ready outside SEND_DRIVE SHALL be ignored.
REQ-018 IO_Memory_WR_Enable SHALL never be asserted during send states.

Reset
REQ-019 With RST=0 at a clock edge: state=IDLE, beat/index/address counters=0, and all outputs 0 (IO_Memory_WR_Enable, Send_Valid, Busy, Done_*, Overrun, RAM address/data), with CPU_Bus high-impedance.
REQ-020 Reset mid-operation SHALL abort the transfer immediately; a write pending for the next cycle SHALL be discarded.

Verification
REQ-021 Load N=2 with defaults, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles -> writes 0x2222222211111111 @0 and 0x4444444433333333 @1, one cycle each; Done_Loading pulses once.
REQ-022 Send with RESULT_COUNT=2, RAM[0]=0xAABBCCDD00112233, Bus_Ready held high -> CPU_Bus carries 0x00112233 then 0xAABBCCDD with Send_Valid; Done_Sending pulses after the 4th beat.
REQ-023 Bus_Ready low for 3 cycles in SEND_DRIVE -> the same slice is held stable and beat does not advance.
REQ-024 INT during a load -> Overrun pulses once and the load completes unchanged.
REQ-025 RST low in the cycle after the final beat -> no write occurs, no Done_Loading, state IDLE.
REQ-026 Header N=0 -> no writes; Done_Loading pulses 1 cycle later.
